// File: rtl/cpu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encodings,
// FSM state encoding and the divide-by-zero quotient constant.
package cpu_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } mdState_t;

  // Wide enough for any supported WIDTH; users slice off the low bits.
  localparam int MAX_WIDTH = 64;
  localparam logic [MAX_WIDTH-1:0] DIV0_QUOTIENT = {MAX_WIDTH{1'b1}};

  // Multiply and divide ops occupy the lower half of the op space.
  function automatic logic isArithOp(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  // MULT and DIV are the signed variants (even encodings of the arith group).
  function automatic logic isSignedOp(input logic [2:0] op);
    return (op[2] == 1'b0) && (op[0] == 1'b0);
  endfunction

endpackage

// File: rtl/md_datapath.sv
// Iterative multiply/divide datapath: shift-add multiply, restoring
// shift-subtract divide, and the final sign correction of the result.
module md_datapath
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             load,
  input  logic             step,
  input  logic [2:0]       opSel,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic [WIDTH-1:0] resHi,
  output logic [WIDTH-1:0] resLo
);

  // accR holds the product high half / partial remainder, lowR the
  // multiplier being shifted out / dividend turning into the quotient.
  logic [WIDTH-1:0]   accR, lowR, opndR;
  logic               negAR, negBR, isDivR, divZeroR;

  logic               negAS, negBS;
  logic [WIDTH-1:0]   magAS, magBS;
  logic [WIDTH:0]     sumS, shiftS, diffS;
  logic [WIDTH-1:0]   accNextS, lowNextS;
  logic [2*WIDTH-1:0] prodS, prodFixS;
  logic [WIDTH-1:0]   remFixS, quoFixS;

  // Operand magnitudes and sign flags captured when an operation starts.
  always_comb begin
    negAS = isSignedOp(opSel) & opA[WIDTH-1];
    negBS = isSignedOp(opSel) & opB[WIDTH-1];
    magAS = opA;
    magBS = opB;
    if (negAS) begin
      magAS = -opA;
    end else begin
      magAS = opA;
    end
    if (negBS) begin
      magBS = -opB;
    end else begin
      magBS = opB;
    end
  end

  // One iteration of either algorithm; the divisor/multiplicand sits in opndR.
  always_comb begin
    accNextS = accR;
    lowNextS = lowR;
    sumS     = {1'b0, accR} + {1'b0, opndR};
    shiftS   = {accR, lowR[WIDTH-1]};
    diffS    = shiftS - {1'b0, opndR};
    if (isDivR) begin
      // Top bit of the difference set means the trial subtract went negative.
      if (diffS[WIDTH] == 1'b0) begin
        accNextS = diffS[WIDTH-1:0];
        lowNextS = {lowR[WIDTH-2:0], 1'b1};
      end else begin
        accNextS = shiftS[WIDTH-1:0];
        lowNextS = {lowR[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (lowR[0]) begin
        accNextS = sumS[WIDTH:1];
        lowNextS = {sumS[0], lowR[WIDTH-1:1]};
      end else begin
        accNextS = {1'b0, accR[WIDTH-1:1]};
        lowNextS = {accR[0], lowR[WIDTH-1:1]};
      end
    end
  end

  // Iteration registers: cleared on reset, seeded on load, advanced on step.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      accR     <= '0;
      lowR     <= '0;
      opndR    <= '0;
      negAR    <= 1'b0;
      negBR    <= 1'b0;
      isDivR   <= 1'b0;
      divZeroR <= 1'b0;
    end else if (load) begin
      accR     <= '0;
      lowR     <= opSel[1] ? magAS : magBS;
      opndR    <= opSel[1] ? magBS : magAS;
      negAR    <= negAS;
      negBR    <= negBS;
      isDivR   <= opSel[1];
      divZeroR <= (opB == '0);
    end else if (step) begin
      accR     <= accNextS;
      lowR     <= lowNextS;
    end
  end

  // Sign fix-up. A zero divisor leaves |OpA| in the remainder, so restoring
  // the dividend sign yields OpA itself; the quotient is forced to all ones.
  always_comb begin
    prodS    = {accR, lowR};
    prodFixS = (negAR ^ negBR) ? -prodS : prodS;
    remFixS  = negAR ? -accR : accR;
    quoFixS  = (negAR ^ negBR) ? -lowR : lowR;
    resHi    = prodFixS[2*WIDTH-1:WIDTH];
    resLo    = prodFixS[WIDTH-1:0];
    if (isDivR) begin
      resHi = remFixS;
      if (divZeroR) begin
        resLo = DIV0_QUOTIENT[WIDTH-1:0];
      end else begin
        resLo = quoFixS;
      end
    end else begin
      resHi = prodFixS[2*WIDTH-1:WIDTH];
      resLo = prodFixS[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit owning the HI/LO registers. Control FSM,
// iteration counter and HI/LO live here; the arithmetic is in md_datapath.
module mult_div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mdState_t         stateR, nextStateS;
  logic [CNT_W-1:0] cntR;
  logic             busyR, doneR;
  logic [WIDTH-1:0] hiR, loR;

  logic             dpLoadS, dpStepS, doneNextS;
  logic             hiWrS, loWrS;
  logic [WIDTH-1:0] hiNextS, loNextS;
  logic [WIDTH-1:0] dpHiS, dpLoS;

  md_datapath #(.WIDTH(WIDTH)) uDatapath (
    .clk   (Clk),
    .rstN  (Rst_n),
    .load  (dpLoadS),
    .step  (dpStepS),
    .opSel (Op),
    .opA   (OpA),
    .opB   (OpB),
    .resHi (dpHiS),
    .resLo (dpLoS)
  );

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stateR <= ST_IDLE;
    end else begin
      stateR <= nextStateS;
    end
  end

  // Next state and control; Flush outranks Start and any pending write-back.
  always_comb begin
    nextStateS = stateR;
    dpLoadS    = 1'b0;
    dpStepS    = 1'b0;
    doneNextS  = 1'b0;
    hiWrS      = 1'b0;
    loWrS      = 1'b0;
    hiNextS    = hiR;
    loNextS    = loR;
    case (stateR)
      ST_IDLE: begin
        if (Flush) begin
          nextStateS = ST_IDLE;
        end else if (Start) begin
          if (isArithOp(Op)) begin
            dpLoadS    = 1'b1;
            nextStateS = ST_RUN;
          end else if (Op == OP_MTHI) begin
            hiWrS     = 1'b1;
            hiNextS   = OpA;
            doneNextS = 1'b1;
          end else if (Op == OP_MTLO) begin
            loWrS     = 1'b1;
            loNextS   = OpA;
            doneNextS = 1'b1;
          end else begin
            nextStateS = ST_IDLE;
          end
        end else begin
          nextStateS = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (Flush) begin
          nextStateS = ST_IDLE;
        end else begin
          dpStepS = 1'b1;
          if (cntR == '0) begin
            nextStateS = ST_FIX;
          end else begin
            nextStateS = ST_RUN;
          end
        end
      end
      ST_FIX: begin
        nextStateS = ST_IDLE;
        if (Flush) begin
          doneNextS = 1'b0;
        end else begin
          hiWrS     = 1'b1;
          loWrS     = 1'b1;
          hiNextS   = dpHiS;
          loNextS   = dpLoS;
          doneNextS = 1'b1;
        end
      end
      default: begin
        nextStateS = ST_IDLE;
      end
    endcase
  end

  // Iteration counter: WIDTH-1 down to 0 gives WIDTH iterations in RUN.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cntR <= '0;
    end else if (dpLoadS) begin
      cntR <= CNT_W'(WIDTH - 1);
    end else if (dpStepS && (cntR != '0)) begin
      cntR <= cntR - CNT_W'(1);
    end
  end

  // Registered Busy/Done and the architectural HI/LO registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      busyR <= 1'b0;
      doneR <= 1'b0;
      hiR   <= '0;
      loR   <= '0;
    end else begin
      busyR <= (nextStateS != ST_IDLE);
      doneR <= doneNextS;
      if (hiWrS) begin
        hiR <= hiNextS;
      end
      if (loWrS) begin
        loR <= loNextS;
      end
    end
  end

  assign Busy = busyR;
  assign Done = doneR;
  assign Hi   = hiR;
  assign Lo   = loR;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative 32-bit multiply/divide unit in the EX stage. It owns the HI/LO architectural registers.
- The lo output drives input C of the EX/WB 3-to-1 result mux (sel = 2'b10 selects it for MFLO paths).
- Start/busy/done handshake; the pipeline control stalls while busy is high.

Parameters:
- WIDTH, 32: operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- Clk in 1: rising-edge clock.
- Rst_n in 1: asynchronous, active-low reset.
- Start in 1: request strobe; sampled only in IDLE.
- Op in 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others are no-op.
- OpA in WIDTH: rs operand (dividend / multiplicand / MTHI-MTLO source).
- OpB in WIDTH: rt operand (divisor / multiplier).
- Flush in 1: abort the in-flight operation.
- Busy out 1: operation in progress.
- Done out 1: one-cycle pulse when HI/LO have been updated.
- Hi out WIDTH: HI register.
- Lo out WIDTH: LO register.

Behaviour:
- Reset (Rst_n low, asynchronous): state IDLE, Hi = 0, Lo = 0, Busy = 0, Done = 0, all internal accumulators cleared.
- States: IDLE, RUN, FIX.
- IDLE with Start = 1:
  - MULT/MULTU/DIV/DIVU: latch operands and go to RUN. For signed ops, operands are converted to magnitudes and sign flags are latched. Iteration counter is set to WIDTH-1.
  - MTHI/MTLO: write OpA to Hi/Lo at that edge, pulse Done next cycle, stay IDLE, Busy stays 0.
  - Undefined Op: ignored, no Done.
- RUN: one iteration per cycle, WIDTH cycles total.
  - Multiply: shift-add into a 2*WIDTH-bit product.
  - Divide: restoring shift-subtract into quotient/remainder.
  - Counter reaching 0 moves to FIX.
- FIX: apply signs, write Hi/Lo, assert Done for exactly one cycle, return to IDLE.
  - Signed multiply: negate the 64-bit product if signs differ.
  - Signed divide: quotient negative if signs differ; remainder takes the dividend's sign.
- Latency: Start sampled at edge 0; Busy = 1 after edges 0..WIDTH; Hi/Lo updated and Done = 1 after edge WIDTH+1. Busy falls on the same edge Done rises. Total 33 cycles for WIDTH = 32.
- Result mapping:
  - Multiply: Hi = product[63:32], Lo = product[31:0].
  - Divide: Lo = quotient, Hi = remainder.
- Divide by zero (OpB = 0): Lo = all ones, Hi = OpA. Full latency is still taken.
- Signed overflow (DIV of 0x80000000 by 0xFFFFFFFF): Lo = 0x80000000, Hi = 0.
- Start while Busy: ignored; no queueing.
- Flush:
  - In RUN or FIX: return to IDLE next edge. Hi/Lo are not modified, no Done, Busy = 0.
  - In IDLE: has priority over Start; the request is dropped.
- Start and Flush in the same IDLE cycle: Flush wins.
- Hi/Lo change only on MTHI/MTLO in IDLE or in FIX; they hold during RUN.
- Reset mid-RUN: immediate return to reset values; the partial result is discarded.

Decomposition:
- Shared package (cpu_pkg):
  - Op encodings as localparams: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO.
  - State encoding for IDLE/RUN/FIX.
  - DIV0_QUOTIENT constant.
- One sub-module: md_datapath, holding the shift/add/subtract registers and the sign-fix logic. The FSM, counter and HI/LO registers stay in mult_div_unit.

Test Plan:
- MULTU with OpA = 0xFFFFFFFF, OpB = 0x00000002 -> Busy for 33 cycles, then Done pulse with Hi = 0x00000001, Lo = 0xFFFFFFFE.
- MULT with OpA = 0xFFFFFFFD (-3), OpB = 7 -> Hi = 0xFFFFFFFF, Lo = 0xFFFFFFEB (-21), Done exactly 33 cycles after Start.
- DIV with OpA = 0xFFFFFFF9 (-7), OpB = 2 -> Lo = 0xFFFFFFFD (-3), Hi = 0xFFFFFFFF (-1).
- DIVU with OpA = 100, OpB = 0 -> Lo = 0xFFFFFFFF, Hi = 100.
- MTLO 0x12345678, then Start MULTU while Busy with a second Start mid-run -> second Start ignored, exactly one Done for the multiply.
- Flush at cycle 10 of DIV after MTHI 0xA5A5A5A5 -> Busy drops next cycle, no Done, Hi = 0xA5A5A5A5 unchanged.
- Rst_n asserted mid-RUN -> Hi = Lo = 0 and Busy = Done = 0 without waiting for a clock edge.
